// File: rtl/imem_loader.sv
// imem_loader: length-prefixed byte-stream writer for the instruction memory image.
// Stream format: N_lo, N_hi, then N*BYTES data bytes packed little-endian into
// DATA_WIDTH words written at addresses 0..N-1.
// Optional feature: define LOADER_CHECKSUM_EN to add a trailing XOR checksum byte
// and the CHECK state that compares it.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned BYTES  = DATA_WIDTH / 8;
  localparam int unsigned BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BIDX_W-1:0] LAST_BIDX = BIDX_W'(BYTES - 1);
  // Largest legal word count is the full memory depth; 17 bits covers ADDR_WIDTH=16.
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
`ifdef LOADER_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_DONE
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t ST_AFTER_DATA = ST_CHECK;
`else
  localparam state_t ST_AFTER_DATA = ST_DONE;
`endif

  state_t state_q, state_d;

  logic [7:0]            len_lo_q,   len_lo_d;
  logic [15:0]           remain_q,   remain_d;
  logic [BIDX_W-1:0]     byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-1:0] pack_q,     pack_d;
  logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            xor_q,      xor_d;
`endif

  logic                  in_ready_d, busy_d, done_d, error_d, we_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;

  logic                  accept_c;
  logic [15:0]           len_c;

  assign accept_c = in_valid && in_ready;
  assign len_c    = {in_data, len_lo_q};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, datapath next values and registered-output next values
  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    remain_d   = remain_q;
    byte_idx_d = byte_idx_q;
    pack_d     = pack_q;
    addr_cnt_d = addr_cnt_q;
`ifdef LOADER_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    error_d    = error;
    we_d       = 1'b0;
    addr_d     = mem_addr;
    wdata_d    = mem_wdata;

    if (abort) begin
      // Partial word is dropped; error flag is left as is.
      state_d    = ST_IDLE;
      byte_idx_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d    = ST_LEN_LO;
            error_d    = 1'b0;
            addr_cnt_d = '0;
            byte_idx_d = '0;
`ifdef LOADER_CHECKSUM_EN
            xor_d      = '0;
`endif
          end
        end
        ST_LEN_LO: begin
          if (accept_c) begin
            len_lo_d = in_data;
            state_d  = ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (accept_c) begin
            remain_d = len_c;
            if ({1'b0, len_c} > MAX_WORDS) begin
              error_d = 1'b1;
              state_d = ST_IDLE;
            end else if (len_c == 16'd0) begin
              state_d = ST_AFTER_DATA;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (accept_c) begin
            pack_d[{byte_idx_q, 3'b000} +: 8] = in_data;
`ifdef LOADER_CHECKSUM_EN
            xor_d = xor_q ^ in_data;
`endif
            if (byte_idx_q == LAST_BIDX) begin
              byte_idx_d = '0;
              we_d       = 1'b1;
              addr_d     = addr_cnt_q;
              wdata_d    = pack_d;
              addr_cnt_d = addr_cnt_q + ADDR_WIDTH'(1);
              remain_d   = remain_q - 16'd1;
              if (remain_q == 16'd1) begin
                state_d = ST_AFTER_DATA;
              end
            end else begin
              byte_idx_d = byte_idx_q + BIDX_W'(1);
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (accept_c) begin
            if (in_data != xor_q) begin
              error_d = 1'b1;
            end
            state_d = ST_DONE;
          end
        end
`endif
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Status outputs are registered from the next state so they align with it.
    in_ready_d = (state_d == ST_LEN_LO) || (state_d == ST_LEN_HI) || (state_d == ST_DATA)
`ifdef LOADER_CHECKSUM_EN
                 || (state_d == ST_CHECK)
`endif
                 ;
    busy_d = in_ready_d;
    done_d = (state_d == ST_DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo_q   <= '0;
      remain_q   <= '0;
      byte_idx_q <= '0;
      pack_q     <= '0;
      addr_cnt_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      xor_q      <= '0;
`endif
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      len_lo_q   <= len_lo_d;
      remain_q   <= remain_d;
      byte_idx_q <= byte_idx_d;
      pack_q     <= pack_d;
      addr_cnt_q <= addr_cnt_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
      in_ready   <= in_ready_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
      mem_we     <= we_d;
      mem_addr   <= addr_d;
      mem_wdata  <= wdata_d;
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream writer that fills the CPU's synchronous instruction ROM/RAM image at run time. It accepts a length-prefixed byte stream through a valid/ready handshake, typically from the UART receiver, and packs the bytes little-endian into DATA_WIDTH words. It drives the memory's write port with sequential addresses from 0. It is the write-side counterpart of the instruction memory read port and sits between the host link and the memory array.

## Interface
- ADDR_WIDTH, 8: memory address width; legal range 1..16.
- DATA_WIDTH, 32: word width; must be a multiple of 8. BYTES = DATA_WIDTH/8.

- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE or DONE.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- in_valid  in  1  byte available.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte.
- mem_we  out  1  write strobe, one cycle per word.
- mem_addr  out  ADDR_WIDTH  word address.
- mem_wdata  out  DATA_WIDTH  packed word.
- busy  out  1  high in LEN_LO, LEN_HI, DATA and CHECK.
- done  out  1  high in DONE.
- error  out  1  sticky error flag; cleared by the next accepted start.

## Operation
- A byte is accepted when in_valid && in_ready. in_ready = 1 in LEN_LO, LEN_HI, DATA and CHECK, and 0 otherwise. There is no backpressure from memory.
- The stream is N_lo, N_hi, then N×BYTES data bytes (+1 checksum byte when the checksum feature is enabled). N is a 16-bit word count.
- States and transitions:
  - IDLE: on start, go to LEN_LO.
  - LEN_LO: on accept, latch the low byte and go to LEN_HI.
  - LEN_HI: on accept, latch the high byte, then:
    - if N > 2**ADDR_WIDTH, set error and go to IDLE;
    - if N == 0, go to CHECK when enabled, else DONE;
    - otherwise go to DATA.
  - DATA: each accepted byte shifts into the word, byte k → bits [8k+7:8k], first byte at [7:0]. On the BYTES-th byte, issue a write. After word N-1, go to CHECK when enabled, else DONE.
  - DONE: on start, go to LEN_LO. A start pulse in DONE clears done.
- Address counter: reset to 0 at each accepted start and incremented after every write. The write address is the counter value before increment, so words land at 0..N-1.
- N == 2**ADDR_WIDTH is legal; the counter wraps to 0 only after the final write, which is harmless.
- abort in any state: go to IDLE. A partially packed word is discarded and never written. A write already registered still completes that cycle. error is unchanged.
- start while busy is ignored. A start coincident with abort loses; abort wins.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0; state IDLE.
- start at cycle t → LEN_LO at t+1, with in_ready=1 at t+1.
- Last byte of a word accepted at cycle t → mem_we=1 with registered mem_addr/mem_wdata at t+1, for exactly one cycle.
- Back-to-back bytes at one per cycle are sustained. The maximum write rate is one per BYTES cycles.
- Final write at t+1 and done=1 at t+1: the state moves to DONE together with the registered write. With checksum enabled, done or error follows the checksum byte by one cycle.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - CHECK state exists. An 8-bit XOR of all data bytes, cleared at start, is compared with one trailing byte.
  - On a match, go to DONE.
  - On a mismatch, set error and go to DONE. Words already written remain.
- LOADER_CHECKSUM_EN undefined: no CHECK state or XOR register. The stream ends after the data bytes.

## Test plan
- DATA_WIDTH=32, start, then stream 02 00 78 56 34 12 EF BE AD DE → writes addr0=0x12345678 and addr1=0xDEADBEEF on successive one-cycle strobes; then done=1, error=0.
- N=0 (00 00) → no mem_we; done=1 one cycle after N_hi (checksum disabled).
- ADDR_WIDTH=8, N=0x0101 → error=1, return to IDLE, no writes. N=0x0100 with 1024 bytes → last write at addr 0xFF, done=1.
- Abort after 6 data bytes of N=2 → exactly one write (addr0); no write for the partial word; IDLE; busy=0.
- rst_n asserted mid-DATA → all outputs zero immediately (asynchronously). A subsequent fresh load writes from addr 0.
- With LOADER_CHECKSUM_EN: stream 01 00 11 22 33 44 44 → XOR of data bytes = 0x44, so done=1, error=0. The same stream with trailing 0x45 → error=1.
